// File: rtl/axis_sqrt_if.sv
// AXI-stream bundle used by the axis_* blocks.
// Carries valid/ready/data/last only.
interface Axis_If #(
  parameter int DWIDTH = 32
);
  logic              valid;
  logic              ready;
  logic [DWIDTH-1:0] data;
  logic              last;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/axis_sqrt.sv
// Streaming fixed-point square root, one root bit per stage.
// Restoring digit recurrence, saturating to the signed maximum.
module axis_sqrt #(
  parameter int SAMPLE_WIDTH     = 16,
  parameter int PARALLEL_SAMPLES = 2,
  parameter int SAMPLE_FRAC_BITS = 14
) (
  input logic    clk,
  input logic    reset,
  Axis_If.slave  data_in,
  Axis_If.master data_out
);
  localparam int W  = SAMPLE_WIDTH;
  localparam int P  = PARALLEL_SAMPLES;
  localparam int DW = W * P;
  localparam int SAMPLE_INT_BITS = W - SAMPLE_FRAC_BITS;
  localparam int LATENCY = W + 1;
  localparam int SHIFT =
    2 * SAMPLE_FRAC_BITS - (W - 2 * SAMPLE_INT_BITS);
  localparam int RW = W + SHIFT;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};

  typedef struct packed {
    logic [W+1:0]  rem;
    logic [W-1:0]  root;
    logic [RW-1:0] rad;
    logic          neg;
  } lane_t;

  typedef struct packed {
    logic          vld;
    logic          last;
    lane_t [P-1:0] ln;
  } stg_t;

  function automatic lane_t step(lane_t a);
    lane_t        b;
    logic [W+1:0] cur;
    logic [W+1:0] trial;
    logic         ge;
    cur   = (W+2)'({a.rem, a.rad[RW-1 -: 2]});
    trial = {a.root, 2'b01};
    ge    = (cur >= trial);
    b      = a;
    b.rad  = {a.rad[RW-3:0], 2'b00};
    b.rem  = ge ? (cur - trial) : cur;
    b.root = W'({a.root, ge});
    return b;
  endfunction

  logic          en;
  logic          fire;
  stg_t          stg_d [LATENCY];
  stg_t          stg_q [LATENCY];
  logic          out_valid_d;
  logic          out_valid_q;
  logic          out_last_d;
  logic          out_last_q;
  logic [DW-1:0] out_data_d;
  logic [DW-1:0] out_data_q;

  assign en            = data_out.ready | ~out_valid_q;
  assign data_in.ready = en & ~reset;
  assign fire          = data_in.valid & data_in.ready;

  assign data_out.valid = out_valid_q;
  assign data_out.data  = out_data_q;
  assign data_out.last  = out_last_q;

  // Entry capture, then one root bit resolved per stage
  always_comb begin
    stg_d[0].vld  = fire;
    stg_d[0].last = fire & data_in.last;
    for (int i = 0; i < P; i++) begin
      stg_d[0].ln[i].neg  = data_in.data[i*W+W-1];
      stg_d[0].ln[i].rem  = '0;
      stg_d[0].ln[i].root = '0;
      stg_d[0].ln[i].rad  = data_in.data[i*W+W-1] ?
        '0 : {data_in.data[i*W +: W], {SHIFT{1'b0}}};
    end
    for (int k = 1; k < LATENCY; k++) begin
      stg_d[k].vld  = stg_q[k-1].vld;
      stg_d[k].last = stg_q[k-1].last;
      for (int i = 0; i < P; i++) begin
        stg_d[k].ln[i] = step(stg_q[k-1].ln[i]);
      end
    end
  end

  // Final stage: force negatives to zero and saturate
  always_comb begin
    out_valid_d = stg_q[LATENCY-1].vld;
    out_last_d  = stg_q[LATENCY-1].last;
    out_data_d  = '0;
    for (int i = 0; i < P; i++) begin
      if (stg_q[LATENCY-1].ln[i].neg) begin
        out_data_d[i*W +: W] = '0;
      end else if (stg_q[LATENCY-1].ln[i].root[W-1]) begin
        out_data_d[i*W +: W] = SMAX;
      end else begin
        out_data_d[i*W +: W] = stg_q[LATENCY-1].ln[i].root;
      end
    end
  end

  // Whole pipeline advances together under the global enable
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        stg_q[k].vld  <= 1'b0;
        stg_q[k].last <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      for (int k = 0; k < LATENCY; k++) begin
        stg_q[k] <= stg_d[k];
      end
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: doc/axis_sqrt.md
Name: axis_sqrt

Overview:
- Streaming fixed-point square root. Functionally the inverse of axis_x2.
- Accepts samples in the squared format that axis_x2 emits: signed, SAMPLE_WIDTH bits, SAMPLE_WIDTH-2*SAMPLE_INT_BITS fractional bits.
- Returns the non-negative root in the original Q(SAMPLE_INT_BITS).(SAMPLE_FRAC_BITS) signed format.
- Fully pipelined, one root bit resolved per stage, PARALLEL_SAMPLES lanes per beat, AXI-stream handshake on both sides. Used on RMS and magnitude paths after axis_x2 and accumulation.

Parameters:
- SAMPLE_WIDTH, 16: bits per sample, both input and output.
- PARALLEL_SAMPLES, 2: samples per beat; all lanes are independent.
- SAMPLE_FRAC_BITS, 14: fractional bits of the output format.
- Derived, not overridable: SAMPLE_INT_BITS = SAMPLE_WIDTH-SAMPLE_FRAC_BITS; LATENCY = SAMPLE_WIDTH+1.

Ports:
- clk, input, 1: single clock.
- reset, input, 1: synchronous, active-high.
- data_in, Axis_If slave, DWIDTH=SAMPLE_WIDTH*PARALLEL_SAMPLES: squared samples. Lane i is data[i*SAMPLE_WIDTH+:SAMPLE_WIDTH]. Uses valid, ready, data, last.
- data_out, Axis_If master, DWIDTH=SAMPLE_WIDTH*PARALLEL_SAMPLES: root samples, same lane packing. Uses valid, ready, data, last.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Arithmetic, per lane, on input raw value x (signed):
  - x <= 0: root = 0.
  - Otherwise radicand R = x << SAMPLE_WIDTH, unsigned, 2*SAMPLE_WIDTH bits. The shift always equals SAMPLE_WIDTH because 2*FRAC - (W - 2*INT) = W.
  - r = floor(sqrt(R)), unsigned SAMPLE_WIDTH bits. Bit-exact; truncate, never round.
  - Output = min(r, 2^(SAMPLE_WIDTH-1)-1), saturating to the signed maximum.
- Pipeline structure:
  - Stages 0..SAMPLE_WIDTH-1 are restoring digit-recurrence stages, each resolving one root bit, MSB first. Each stage carries remainder, partial root, a negative flag, valid and last.
  - Stage SAMPLE_WIDTH applies saturation and drives the output register.
- Latency: with data_out.ready held high, a beat accepted on edge t appears with data_out.valid=1 after edge t+LATENCY. Throughput is one beat per cycle.
- Handshake:
  - Global pipeline enable: en = data_out.ready | ~data_out.valid. data_in.ready = en & ~reset.
  - When en=0, every stage holds, including bubbles.
  - When en=1, all stages shift one position. A stage receives valid=1 only if data_in.valid & data_in.ready.
  - data_out.valid/data/last stay stable while valid & ~ready; a transfer never drops or duplicates a beat.
- last: delayed alongside its beat through all stages, unchanged. Bubble stages carry last=0.
- Reset:
  - All stage valid bits clear. data_out.valid=0, data_out.data=0, data_out.last=0, data_in.ready=0.
  - Reset asserted mid-stream discards every in-flight beat; nothing is emitted after reset deasserts until new input arrives.
  - Datapath registers other than the output need not be cleared.
- Boundaries:
  - x = most negative value: output 0.
  - x = max positive: output saturates to 0x7FFF (16-bit default).
  - A full pipeline with ready=0 accepts nothing.
  - ready rising in the same cycle as input valid transfers both ends on that edge.

Test Plan:
- Directed values, ready=1, lane0/lane1:
  - 0x1000/0x0400 -> 0x4000/0x2000.
  - 0x0001/0x0003 -> 0x0100/0x01BB.
  - 0x2000/0x0000 -> 0x5A82/0x0000.
  - Each appears exactly 17 cycles after acceptance.
- Saturation/negative: 0x4000, 0x7FFF, 0x8000, 0xFFFF -> 0x7FFF, 0x7FFF, 0x0000, 0x0000.
- Random stream with data_in.valid and data_out.ready each toggled at 50% for 2000 cycles:
  - Received count equals sent count, order preserved.
  - Every output equals the floor-sqrt model exactly.
  - last positions match input.
- Backpressure hold: fill the pipeline with ready=0 for 40 cycles.
  - data_in.ready=0 throughout and the output beat is held stable.
  - Release: 17 beats drain back-to-back, then new input flows.
- Reset mid-stream: assert reset for 1 cycle with 10 beats in flight.
  - Zero of those beats appear; outputs are 0 the cycle after the reset edge.
  - Next accepted beat emerges 17 cycles later.
- Round trip: random x in Q2.14 with |x| < 2, passed through axis_x2 then axis_sqrt.
  - Result within 2 LSB of |x|.
